gt_sweep_checker: RTL and testbench

//  Synthesizable exhaustive self-test for an unsigned W-bit greater-than comparator.
//  It drives every (a,b) operand pair to the comparator under test and samples the

---
 rtl/gt_sweep_checker.sv | 101 ++++++++++
 tb/tb_gt_sweep_checker.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/gt_sweep_checker.sv
// gt_sweep_checker: exhaustive on-board sweep of an unsigned W-bit greater-than comparator.
// Define GT_FAIL_CAPTURE_EN to add capture of the first mismatching vector (fail_a/fail_b/fail_seen).
module gt_sweep_checker #(
   parameter int W      = 2,
   parameter int SETTLE = 1,
   parameter int ERR_W  = 8
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             dut_gt,
   output logic [W-1:0]     a,
   output logic [W-1:0]     b,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_cnt
`ifdef GT_FAIL_CAPTURE_EN
   ,
   output logic [W-1:0]     fail_a,
   output logic [W-1:0]     fail_b,
   output logic             fail_seen
`endif
);
   localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
   localparam logic [SW-1:0] SCNT_INIT = SW'(SETTLE);
   typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;
   state_t           state_q;
   logic [W-1:0]     a_q, b_q;
   logic [SW-1:0]    scnt_q;
   logic [ERR_W-1:0] err_q, err_d;
   logic             busy_q, done_q;
   logic             mismatch, last, sample, launch;
   // Golden compare uses the vector currently driven, not the one about to be loaded.
   assign mismatch = dut_gt != (a_q > b_q);
   assign last     = (&a_q) & (&b_q);
   assign sample   = state_q == HOLD && scnt_q == '0;
   assign launch   = start && state_q != HOLD;
   assign err_d    = (mismatch && !(&err_q)) ? err_q + 1'b1 : err_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         scnt_q  <= '0;
         err_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (state_q != HOLD) begin
         if (start) begin
            state_q <= HOLD;
            a_q     <= '0;
            b_q     <= '0;
            scnt_q  <= SCNT_INIT;
            err_q   <= '0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
         end
      end else if (scnt_q != '0) begin
         scnt_q <= scnt_q - 1'b1;
      end else begin
         err_q  <= err_d;
         scnt_q <= SCNT_INIT;
         if (last) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
         end else begin
            {a_q, b_q} <= {a_q, b_q} + 1'b1;
         end
      end
   end
   assign a       = a_q;
   assign b       = b_q;
   assign busy    = busy_q;
   assign done    = done_q;
   assign err_cnt = err_q;
   assign pass    = done_q && err_q == '0;
`ifdef GT_FAIL_CAPTURE_EN
   logic [W-1:0] fail_a_q, fail_b_q;
   logic         fail_seen_q;
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fail_a_q    <= '0;
         fail_b_q    <= '0;
         fail_seen_q <= 1'b0;
      end else if (launch) begin
         fail_a_q    <= '0;
         fail_b_q    <= '0;
         fail_seen_q <= 1'b0;
      end else if (sample && mismatch && !fail_seen_q) begin
         fail_a_q    <= a_q;
         fail_b_q    <= b_q;
         fail_seen_q <= 1'b1;
      end
   end
   assign fail_a    = fail_a_q;
   assign fail_b    = fail_b_q;
   assign fail_seen = fail_seen_q;
`endif
endmodule

// File: tb/tb_gt_sweep_checker.sv
// tb_gt_sweep_checker: scoreboard bench driving three checker instances against a modelled comparator.
module tb_gt_sweep_checker;
   typedef struct {
      int err;
      int pass;
      int cyc;
   } exp_t;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic st = 1'b0;
   int   sel = 0;
   int   mode = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t sq[$];
   int   vq[$];
   logic [1:0] a0, b0, a1, b1;
   logic [3:0] a2, b2;
   logic [7:0] e0, e1;
   logic [2:0] e2;
   logic busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
   logic g0, g1, g2, st0, st1, st2;
   int   m_a, m_b, m_e;
   logic m_busy, m_done, m_pass;
`ifdef GT_FAIL_CAPTURE_EN
   logic [1:0] fa0, fb0, fa1, fb1;
   logic [3:0] fa2, fb2;
   logic       fs0, fs1, fs2;
`endif
   always #5 clk = ~clk;
   // Comparator under test: 0 = correct, 1 = inverted, 2 = stuck-at-0.
   function automatic logic model_gt(input int x, input int y, input int m);
      return m == 0 ? (x > y) : m == 1 ? !(x > y) : 1'b0;
   endfunction
   function automatic int exp_err(input int w, input int m, input int ew);
      int n = 0;
      for (int x = 0; x < (1 << w); x++)
         for (int y = 0; y < (1 << w); y++)
            if (model_gt(x, y, m) != (x > y)) n++;
      return n > (1 << ew) - 1 ? (1 << ew) - 1 : n;
   endfunction
   assign g0  = model_gt(32'(a0), 32'(b0), mode);
   assign g1  = model_gt(32'(a1), 32'(b1), mode);
   assign g2  = model_gt(32'(a2), 32'(b2), mode);
   assign st0 = st && sel == 0;
   assign st1 = st && sel == 1;
   assign st2 = st && sel == 2;
   assign m_a    = sel == 0 ? 32'(a0) : sel == 1 ? 32'(a1) : 32'(a2);
   assign m_b    = sel == 0 ? 32'(b0) : sel == 1 ? 32'(b1) : 32'(b2);
   assign m_e    = sel == 0 ? 32'(e0) : sel == 1 ? 32'(e1) : 32'(e2);
   assign m_busy = sel == 0 ? busy0 : sel == 1 ? busy1 : busy2;
   assign m_done = sel == 0 ? done0 : sel == 1 ? done1 : done2;
   assign m_pass = sel == 0 ? pass0 : sel == 1 ? pass1 : pass2;
   gt_sweep_checker #(.W(2), .SETTLE(1), .ERR_W(8)) u0 (
      .clk(clk), .reset_n(rst_n), .start(st0), .dut_gt(g0), .a(a0), .b(b0),
      .busy(busy0), .done(done0), .pass(pass0), .err_cnt(e0)
`ifdef GT_FAIL_CAPTURE_EN
      , .fail_a(fa0), .fail_b(fb0), .fail_seen(fs0)
`endif
   );
   gt_sweep_checker #(.W(2), .SETTLE(0), .ERR_W(8)) u1 (
      .clk(clk), .reset_n(rst_n), .start(st1), .dut_gt(g1), .a(a1), .b(b1),
      .busy(busy1), .done(done1), .pass(pass1), .err_cnt(e1)
`ifdef GT_FAIL_CAPTURE_EN
      , .fail_a(fa1), .fail_b(fb1), .fail_seen(fs1)
`endif
   );
   gt_sweep_checker #(.W(4), .SETTLE(0), .ERR_W(3)) u2 (
      .clk(clk), .reset_n(rst_n), .start(st2), .dut_gt(g2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .pass(pass2), .err_cnt(e2)
`ifdef GT_FAIL_CAPTURE_EN
      , .fail_a(fa2), .fail_b(fb2), .fail_seen(fs2)
`endif
   );
   task automatic chk(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask
   // One full sweep; poke >= 0 pulses start again that many cycles into the sweep.
   task automatic sweep(input int s, input int w, input int settle, input int ew, input int m, input int poke);
      exp_t e;
      int   cyc, lim, n;
      sel  = s;
      mode = m;
      n    = 1 << (2 * w);
      for (int i = 0; i < n; i++) vq.push_back(i);
      sq.push_back('{exp_err(w, m, ew), exp_err(w, m, ew) == 0, n * (settle + 1)});
      lim = n * (settle + 1) + 20;
      @(negedge clk);
      st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      chk("busy_after_start", m_busy, 1);
      chk("done_clr", m_done, 0);
      chk("err_clr", m_e, 0);
      chk("pass_clr", m_pass, 0);
      cyc = 0;
      while (!m_done && cyc < lim) begin
         if (cyc % (settle + 1) == 0 && vq.size() > 0) chk("vec", m_a * (1 << w) + m_b, vq.pop_front());
         st = (cyc == poke);
         @(negedge clk);
         cyc++;
      end
      st = 1'b0;
      chk("done_rise", m_done, 1);
      chk("vec_left", vq.size(), 0);
      vq.delete();
      e = sq.pop_front();
      chk("done_cyc", cyc, e.cyc);
      chk("err_cnt", m_e, e.err);
      chk("pass", m_pass, e.pass);
      chk("busy_done", m_busy, 0);
      chk("a_final", m_a, (1 << w) - 1);
      chk("b_final", m_b, (1 << w) - 1);
      repeat (3) @(negedge clk);
      chk("done_hold", m_done, 1);
   endtask
   initial begin
      repeat (2) @(negedge clk);
      chk("rst_a", m_a, 0);
      chk("rst_b", m_b, 0);
      chk("rst_busy", m_busy, 0);
      chk("rst_done", m_done, 0);
      chk("rst_pass", m_pass, 0);
      chk("rst_err", m_e, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      sweep(0, 2, 1, 8, 0, -1);
      sweep(0, 2, 1, 8, 1, 10);
      sweep(0, 2, 1, 8, 2, -1);
`ifdef GT_FAIL_CAPTURE_EN
      chk("fail_seen", fs0, 1);
      chk("fail_a", fa0, 1);
      chk("fail_b", fb0, 0);
`endif
      sweep(1, 2, 0, 8, 1, -1);
      sweep(2, 4, 0, 3, 1, -1);
      sel  = 0;
      mode = 1;
      @(negedge clk);
      st = 1'b1;
      @(negedge clk);
      st = 1'b0;
      repeat (10) @(negedge clk);
      chk("mid_vec", m_a * 4 + m_b, 5);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_a", m_a, 0);
      chk("mid_rst_b", m_b, 0);
      chk("mid_rst_busy", m_busy, 0);
      chk("mid_rst_done", m_done, 0);
      chk("mid_rst_pass", m_pass, 0);
      chk("mid_rst_err", m_e, 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("idle_no_done", m_done, 0);
      chk("idle_no_busy", m_busy, 0);
      sweep(0, 2, 1, 8, 0, -1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
